// File: rtl/alu_mem_if.sv
// alu_mem_if: operand, result and memory-port bundle shared by alu_mem_unit and its users
interface alu_mem_if;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_out;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_cntrl;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] write_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] read_data;
  modport master (
    output add_a, add_b, alu_a, alu_b, alu_cntrl, write_data, mem_read, mem_write,
    input  add_out, alu_result, zero, read_data
  );
  modport slave (
    input  add_a, add_b, alu_a, alu_b, alu_cntrl, write_data, mem_read, mem_write,
    output add_out, alu_result, zero, read_data
  );
endinterface

// File: rtl/alu_mem_unit.sv
// alu_mem_unit: address adder, 32-bit ALU and a 256x32 data memory addressed by the ALU result
module alu_mem_unit (
  input logic     clk,
  input logic     rst,
  alu_mem_if.slave bus
);
  logic [31:0] mem_q [256];
  logic [7:0]  idx;
  logic        slt;
  assign slt = $signed(bus.alu_a) < $signed(bus.alu_b);
  assign bus.add_out = bus.add_a + bus.add_b;
  assign bus.alu_result = bus.alu_cntrl == 3'b000 ? bus.alu_a & bus.alu_b :
                          bus.alu_cntrl == 3'b001 ? bus.alu_a | bus.alu_b :
                          bus.alu_cntrl == 3'b010 ? bus.alu_a + bus.alu_b :
                          bus.alu_cntrl == 3'b110 ? bus.alu_a - bus.alu_b :
                          bus.alu_cntrl == 3'b111 ? {31'b0, slt} : 32'b0;
  assign bus.zero = bus.alu_result == 32'b0;
  // Byte address aliases every 1 KiB; only the word index selects storage
  assign idx = bus.alu_result[9:2];
  assign bus.read_data = bus.mem_read ? mem_q[idx] : 32'b0;
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < 256; i++) mem_q[i] <= 32'b0;
    else if (bus.mem_write)
      mem_q[idx] <= bus.write_data;
endmodule

// File: tb/tb_alu_mem_unit.sv
// tb_alu_mem_unit: table, random and directed-sequence checks of alu_mem_unit
module tb_alu_mem_unit;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  logic [31:0] model [256];
  alu_mem_if bus ();
  alu_mem_unit dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, res;
    logic        z;
    logic [31:0] pa, pb, psum;
  } vec_t;
  vec_t tv [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd6: return a - b;
      3'd7: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr % 32'd1024) / 32'd4);
  endfunction

  task automatic set_addr(input logic [31:0] addr);
    logic [31:0] off;
    off = $urandom;
    bus.alu_cntrl = 3'b010;
    bus.alu_a = addr - off;
    bus.alu_b = off;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = 32'd0;
  endtask

  initial begin
    tv[0]  = '{3'b110, 32'd7, 32'd7, 32'd0, 1'b1, 32'h4, 32'hFFFF_FFFC, 32'h0};
    tv[1]  = '{3'b010, 32'd7, 32'd7, 32'd14, 1'b0, 32'h4, 32'h10, 32'h14};
    tv[2]  = '{3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 32'h1000, 32'h4, 32'h1004};
    tv[3]  = '{3'b001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0};
    tv[4]  = '{3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0};
    tv[5]  = '{3'b111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'h1234_0000, 32'h5678, 32'h1234_5678};
    tv[6]  = '{3'b011, 32'd5, 32'd3, 32'd0, 1'b1, 32'h0, 32'h0, 32'h0};
    tv[7]  = '{3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000};
    tv[8]  = '{3'b101, 32'hAAAA_AAAA, 32'h5555_5555, 32'd0, 1'b1, 32'h3, 32'h5, 32'h8};
    tv[9]  = '{3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 32'hFFFF_FFF0, 32'h20, 32'h10};
    tv[10] = '{3'b110, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'hDEAD_0000, 32'hBEEF, 32'hDEAD_BEEF};
    tv[11] = '{3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h1, 32'h1, 32'h2};
    clear_model();
    rst = 1'b0;
    bus.add_a = 32'h0; bus.add_b = 32'h0;
    bus.alu_a = 32'h0; bus.alu_b = 32'h0; bus.alu_cntrl = 3'b010;
    bus.write_data = 32'hFFFF_FFFF; bus.mem_read = 1'b1; bus.mem_write = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      set_addr(32'(i * 4));
      #1 chk("reset_read_zero", bus.read_data, 32'd0);
    end
    bus.add_a = 32'h11; bus.add_b = 32'h22;
    #1 chk("reset_add_out", bus.add_out, 32'h33);
    bus.mem_write = 1'b0;
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.alu_cntrl = tv[i].op; bus.alu_a = tv[i].a; bus.alu_b = tv[i].b;
      bus.add_a = tv[i].pa; bus.add_b = tv[i].pb;
      #1;
      chk($sformatf("vec%0d_result", i), bus.alu_result, tv[i].res);
      chk($sformatf("vec%0d_zero", i), {31'b0, bus.zero}, {31'b0, tv[i].z});
      chk($sformatf("vec%0d_add", i), bus.add_out, tv[i].psum);
    end
    for (int i = 0; i < 200; i++) begin
      logic [31:0] e;
      bus.alu_cntrl = 3'($urandom_range(0, 7));
      bus.alu_a = $urandom;
      bus.alu_b = ($urandom_range(0, 3) == 0) ? bus.alu_a : $urandom;
      bus.add_a = $urandom; bus.add_b = $urandom;
      #1;
      e = ref_alu(bus.alu_cntrl, bus.alu_a, bus.alu_b);
      chk("rand_alu", bus.alu_result, e);
      chk("rand_zero", {31'b0, bus.zero}, {31'b0, e == 32'd0});
      chk("rand_add", bus.add_out, bus.add_a + bus.add_b);
    end
    @(negedge clk);
    set_addr(32'd8); bus.write_data = 32'hDEAD_BEEF; bus.mem_write = 1'b1; bus.mem_read = 1'b0;
    @(posedge clk) #1 bus.mem_write = 1'b0;
    model[2] = 32'hDEAD_BEEF;
    bus.mem_read = 1'b1;
    #1 chk("wr_rd_8", bus.read_data, 32'hDEAD_BEEF);
    bus.mem_read = 1'b0;
    #1 chk("rd_disabled", bus.read_data, 32'd0);
    bus.mem_read = 1'b1;
    set_addr(32'd8 + 32'd1024);
    #1 chk("alias_1032", bus.read_data, 32'hDEAD_BEEF);
    @(negedge clk);
    set_addr(32'd8); bus.write_data = 32'h1234_5678; bus.mem_write = 1'b1;
    #1 chk("rbw_before", bus.read_data, 32'hDEAD_BEEF);
    @(posedge clk) #1 chk("rbw_after", bus.read_data, 32'h1234_5678);
    model[2] = 32'h1234_5678;
    bus.mem_write = 1'b0;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] addr;
      logic rd, wr;
      int w;
      @(negedge clk);
      addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)) + ($urandom << 10);
      w = word_of(addr);
      rd = 1'($urandom); wr = 1'($urandom);
      set_addr(addr);
      bus.write_data = $urandom; bus.mem_read = rd; bus.mem_write = wr;
      #1 chk("rand_rd_pre", bus.read_data, rd ? model[w] : 32'd0);
      @(posedge clk) #1;
      if (wr) model[w] = bus.write_data;
      chk("rand_rd_post", bus.read_data, rd ? model[w] : 32'd0);
    end
    @(negedge clk);
    set_addr(32'd8); bus.mem_read = 1'b1; bus.mem_write = 1'b0;
    #1 chk("pre_reset_8", bus.read_data, model[2]);
    @(negedge clk);
    bus.mem_write = 1'b1; bus.write_data = 32'hCAFE_F00D;
    #2 rst = 1'b0;
    clear_model();
    #1 chk("async_clear_8", bus.read_data, 32'd0);
    @(posedge clk) #1 chk("no_write_in_reset", bus.read_data, 32'd0);
    set_addr(32'd0);
    #1 chk("async_clear_0", bus.read_data, 32'd0);
    set_addr(32'd8);
    @(negedge clk) rst = 1'b1;
    bus.write_data = 32'hAAAA_5555;
    #1 chk("release_no_write", bus.read_data, 32'd0);
    @(posedge clk) #1 chk("first_write_after_release", bus.read_data, 32'hAAAA_5555);
    bus.mem_write = 1'b0;
    model[2] = 32'hAAAA_5555;
    for (int i = 0; i < 256; i++) begin
      set_addr(32'(i * 4));
      #1 chk("post_reset_scan", bus.read_data, model[i]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
